// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter granting two requesters one-at-a-time access to a shared combinational ALU
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic [OP_WIDTH-1:0]   req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [OP_WIDTH-1:0]   req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic                  req1_ready_o,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_data_o,
    output logic                  rsp0_zero_o,
    input  logic                  rsp0_ready_i,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_data_o,
    output logic                  rsp1_zero_o,
    input  logic                  rsp1_ready_i,
    output logic [OP_WIDTH-1:0]   alu_operation_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  alu_zero_i
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state, state_nx;
    logic                  owner, last, g0, g1, idle, exec, resp, done;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic                  zero_q;
    always_comb begin
        idle     = state == IDLE;
        exec     = state == EXEC;
        resp     = state == RESP;
        g0       = req0_valid_i & (~req1_valid_i | last);
        g1       = req1_valid_i & (~req0_valid_i | ~last);
        done     = owner ? rsp1_ready_i : rsp0_ready_i;
        state_nx = idle ? ((g0 | g1) ? EXEC : IDLE) :
                   exec ? RESP :
                   resp ? (done ? IDLE : RESP) : IDLE;
    end
    // reset gates the grant so valids held during reset are not acknowledged
    assign req0_ready_o    = reset & idle & g0;
    assign req1_ready_o    = reset & idle & g1;
    assign alu_operation_o = exec ? op_q : '0;
    assign alu_a_o         = exec ? a_q : '0;
    assign alu_b_o         = exec ? b_q : '0;
    assign rsp0_valid_o    = resp & ~owner;
    assign rsp1_valid_o    = resp & owner;
    assign rsp0_data_o     = rsp0_valid_o ? res_q : '0;
    assign rsp1_data_o     = rsp1_valid_o ? res_q : '0;
    assign rsp0_zero_o     = rsp0_valid_o & zero_q;
    assign rsp1_zero_o     = rsp1_valid_o & zero_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (idle & (g0 | g1)) begin
                owner <= g1;
                last  <= g1;
                op_q  <= g1 ? req1_op_i : req0_op_i;
                a_q   <= g1 ? req1_a_i : req0_a_i;
                b_q   <= g1 ? req1_b_i : req0_b_i;
            end
            if (exec) begin
                res_q  <= alu_data_i;
                zero_q <= alu_zero_i;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    logic        clk, reset;
    logic        v0, v1, rr0, rr1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_zero_o, rsp1_zero_o;
    logic [31:0] rsp0_data_o, rsp1_data_o, alu_a_o, alu_b_o, alu_data_i;
    logic [3:0]  alu_operation_o;
    logic        alu_zero_i;
    int          checks = 0, errors = 0;
    int          m_own = -1, m_age = 0, m_last = 1;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    int          gq[$];

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(req0_ready_o),
        .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(req1_ready_o),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_zero_o(rsp0_zero_o), .rsp0_ready_i(rr0),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_zero_o(rsp1_zero_o), .rsp1_ready_i(rr1),
        .alu_operation_o(alu_operation_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a ^ b;
            4'd3: return a + b;
            4'd4: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_data_i = alu_f(alu_operation_o, alu_a_o, alu_b_o);
    assign alu_zero_i = alu_data_i == 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_data_o, rsp0_zero_o, rsp1_valid_o,
                  rsp1_data_o, rsp1_zero_o, alu_operation_o, alu_a_o, alu_b_o}, 192'd0);
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_age  = 0;
        m_last = 1;
    endtask

    // one clock: compare outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        logic        e_r0, e_r1, ex, rv0, rv1;
        logic [31:0] res;
        @(negedge clk);
        e_r0 = reset && m_own < 0 && v0 && (!v1 || m_last == 1);
        e_r1 = reset && m_own < 0 && v1 && (!v0 || m_last == 0);
        ex   = reset && m_own >= 0 && m_age == 0;
        rv0  = reset && m_own == 0 && m_age > 0;
        rv1  = reset && m_own == 1 && m_age > 0;
        res  = alu_f(m_op, m_a, m_b);
        chk("ready", {req0_ready_o, req1_ready_o}, {e_r0, e_r1});
        chk("alu", {alu_operation_o, alu_a_o, alu_b_o}, ex ? {m_op, m_a, m_b} : 68'd0);
        chk("rsp0", {rsp0_valid_o, rsp0_zero_o, rsp0_data_o}, rv0 ? {1'b1, res == 32'd0, res} : 34'd0);
        chk("rsp1", {rsp1_valid_o, rsp1_zero_o, rsp1_data_o}, rv1 ? {1'b1, res == 32'd0, res} : 34'd0);
        @(posedge clk);
        if (reset) begin
            if (m_own < 0) begin
                if (e_r0) begin
                    m_own = 0; m_last = 0; m_age = 0; m_op = op0; m_a = a0; m_b = b0; gq.push_back(0);
                end else if (e_r1) begin
                    m_own = 1; m_last = 1; m_age = 0; m_op = op1; m_a = a1; m_b = b1; gq.push_back(1);
                end
            end else if (m_age == 0) m_age = 1;
            else if ((m_own == 0 && rr0) || (m_own == 1 && rr1)) m_own = -1;
        end
        #1;
    endtask

    initial begin
        logic [3:0] order;
        reset = 1'b0;
        model_reset();
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
        op0 = 4'd3; a0 = 32'd10; b0 = 32'd20;
        op1 = 4'd4; a1 = 32'd50; b1 = 32'd8;
        #1 chk_all_zero("reset_out");
        step();
        step();
        reset = 1'b1;
        gq.delete();
        for (int i = 0; i < 12; i++) step();
        order = 4'hf;
        if (gq.size() >= 4) order = {gq[0][0], gq[1][0], gq[2][0], gq[3][0]};
        chk("rr_count", gq.size(), 4);
        chk("rr_order", order, 4'b0101);
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        step();

        v0 = 1'b1; op0 = 4'd3; a0 = 32'd5; b0 = 32'd7;
        step();
        v0 = 1'b0;
        chk("d032_alu", {alu_operation_o, alu_a_o, alu_b_o}, {4'd3, 32'd5, 32'd7});
        step();
        chk("d032_rsp", {rsp0_valid_o, rsp0_data_o, rsp0_zero_o}, {1'b1, 32'd12, 1'b0});
        rr0 = 1'b1;
        step();
        rr0 = 1'b0;

        v1 = 1'b1; op1 = 4'd3; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
        step();
        v1 = 1'b0;
        step();
        chk("d033_rsp", {rsp1_valid_o, rsp1_data_o, rsp1_zero_o}, {1'b1, 32'd0, 1'b1});
        rr1 = 1'b1;
        step();
        rr1 = 1'b0;

        v0 = 1'b1; op0 = 4'd2; a0 = $urandom; b0 = $urandom;
        step();
        v0 = 1'b0; v1 = 1'b1; op1 = 4'd1; a1 = $urandom; b1 = $urandom;
        step();
        for (int i = 0; i < 10; i++) step();
        rr0 = 1'b1;
        step();
        rr0 = 1'b0; rr1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        v1 = 1'b0;
        step();

        v0 = 1'b1; op0 = 4'd3; a0 = 32'd1; b0 = 32'd2;
        step();
        v0 = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1 chk_all_zero("midexec_out");
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        v0 = 1'b1; op0 = 4'd4; a0 = 32'd9; b0 = 32'd9;
        step();
        v0 = 1'b0;
        step();
        chk("post_reset_rsp", {rsp0_valid_o, rsp0_data_o, rsp0_zero_o}, {1'b1, 32'd0, 1'b1});
        rr0 = 1'b1;
        step();

        for (int i = 0; i < 1500; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 7));
            a0  = $urandom;
            a1  = $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? ~a1 + 32'd1 : $urandom;
            step();
        end
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter OP_WIDTH, default 4, meaning ALU operation code width.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid_i  input  1  requester N (N=0,1) operation pending.
REQ-006 SHALL have ports reqN_op_i  input  OP_WIDTH  requester N ALU operation code.
REQ-007 SHALL have ports reqN_a_i, reqN_b_i  input  DATA_WIDTH  requester N operands.
REQ-008 SHALL have ports reqN_ready_o  output  1  request N accepted this cycle.
REQ-009 SHALL have ports rspN_valid_o  output  1  result for requester N available.
REQ-010 SHALL have ports rspN_data_o  output  DATA_WIDTH  result for requester N.
REQ-011 SHALL have ports rspN_zero_o  output  1  zero flag for requester N.
REQ-012 SHALL have ports rspN_ready_i  input  1  requester N consumes result.
REQ-013 SHALL have ports alu_operation_o  output  OP_WIDTH, alu_a_o and alu_b_o  output  DATA_WIDTH, driving the shared ALU.
REQ-014 SHALL have ports alu_data_i  input  DATA_WIDTH and alu_zero_i  input  1, returned by the shared ALU (combinational).

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-016 IDLE: if any reqN_valid_i=1, SHALL grant one requester, assert its reqN_ready_o combinationally same cycle, latch op/a/b and owner ID at clock edge, go to EXEC.
REQ-017 reqN_ready_o SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester.
REQ-018 Arbitration SHALL be round-robin: when both valid in IDLE, grant the requester not granted last; a single valid requester SHALL be granted regardless of history.
REQ-019 Last-grant pointer SHALL update only on an accepted request.
REQ-020 EXEC (exactly 1 cycle): SHALL drive alu_operation_o/alu_a_o/alu_b_o from latched values, capture alu_data_i and alu_zero_i into result registers at the edge, go to RESP.
REQ-021 Outside EXEC, alu_operation_o, alu_a_o, alu_b_o SHALL be 0.
REQ-022 RESP: rspN_valid_o SHALL be 1 only for the owner; data/zero SHALL hold stable until rspN_ready_i=1; on that edge go to IDLE.
REQ-023 Non-owner rspN_valid_o SHALL be 0; rspN_data_o/rspN_zero_o of non-owner SHALL be 0.
REQ-024 Latency: request accepted at edge T, result captured at T+1, rsp valid from T+1 until handshake; minimum 3 cycles per transaction.
REQ-025 rspN_ready_i while rspN_valid_o=0 SHALL have no effect.
REQ-026 Op codes SHALL pass through unmodified; unsupported codes yield whatever ALU returns (0, zero=1).
REQ-027 A requester dropping valid before ready SHALL not be granted; no request is stored without handshake.

Reset
REQ-028 On reset=0, FSM SHALL enter IDLE asynchronously, abandoning any in-flight transaction without a response.
REQ-029 On reset, all outputs SHALL be 0; latched op/operands/result registers SHALL be 0.
REQ-030 On reset, last-grant pointer SHALL be 1 so requester 0 wins the first simultaneous request.
REQ-031 Request valids present during reset SHALL be granted no earlier than the first rising edge after reset deassertion.

Verification
REQ-032 Single request: req0 op=0011, a=5, b=7 -> req0_ready_o=1 cycle T, alu_a_o=5/alu_b_o=7 at T+1, rsp0_valid_o=1 data=12 zero=0 from T+2 region.
REQ-033 Zero result: req1 op=0011, a=0xFFFFFFFF, b=1 -> rsp1_data_o=0, rsp1_zero_o=1.
REQ-034 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; each response routed only to its owner.
REQ-035 Backpressure: rsp0_ready_i held 0 for 10 cycles -> rsp0_valid_o and data stable, req1_ready_o stays 0, no ALU activity.
REQ-036 Reset mid-EXEC: reset=0 during EXEC -> all outputs 0 immediately, no response after release; next req0 request served normally.
